// File: rtl/stack_pop_unit_if.sv
// Bundle between the core (master) and the RET/RTI stack pop sequencer (slave).
// The underflow flag exists only when STACK_UNDERFLOW_CHK_EN is defined.
interface stack_pop_unit_if;
  logic        ret_req;
  logic        rti_req;
  logic [15:0] sp_in;
  logic [15:0] mem_rdata;
  logic        mem_pop;
  logic [15:0] mem_addr;
  logic [31:0] pc_out;
  logic        pc_load;
  logic [2:0]  flags_out;
  logic        flags_load;
  logic [15:0] sp_out;
  logic        sp_we;
  logic        stall;
`ifdef STACK_UNDERFLOW_CHK_EN
  logic        underflow;
`endif

  modport master (
    output ret_req, rti_req, sp_in, mem_rdata,
    input  mem_pop, mem_addr, pc_out, pc_load, flags_out, flags_load,
    input  sp_out, sp_we, stall
`ifdef STACK_UNDERFLOW_CHK_EN
    , input underflow
`endif
  );

  modport slave (
    input  ret_req, rti_req, sp_in, mem_rdata,
    output mem_pop, mem_addr, pc_out, pc_load, flags_out, flags_load,
    output sp_out, sp_we, stall
`ifdef STACK_UNDERFLOW_CHK_EN
    , output underflow
`endif
  );
endinterface

// File: rtl/stack_pop_unit.sv
// RET/RTI stack pop sequencer: pops PC (and flags for RTI) and returns the new SP.
// Define STACK_UNDERFLOW_CHK_EN to abort requests that would pop past STACK_TOP.
module stack_pop_unit #(
  parameter logic [15:0] STACK_TOP = 16'hFFFF
) (
  input  logic            clk,
  input  logic            reset,
  stack_pop_unit_if.slave bus
);
  // SP and address width follow the width of the empty-stack marker
  localparam int SP_W = $bits(STACK_TOP);

  typedef enum logic [2:0] {IDLE, POP_LO, POP_HI, POP_FL, DRAIN, DONE} state_t;

  state_t          state_reg;
  logic [SP_W-1:0] base_reg;
  logic            rti_mode_reg;
  logic [15:0]     pc_lo_reg;
  logic [15:0]     pc_hi_reg;
  logic            mem_pop_reg;
  logic [SP_W-1:0] mem_addr_reg;
  logic [31:0]     pc_out_reg;
  logic            pc_load_reg;
  logic [2:0]      flags_out_reg;
  logic            flags_load_reg;
  logic [SP_W-1:0] sp_out_reg;
  logic            sp_we_reg;
  logic            stall_reg;

  logic start_w;
  logic short_w;

  assign start_w = bus.ret_req | bus.rti_req;

`ifdef STACK_UNDERFLOW_CHK_EN
  logic [SP_W-1:0] depth_w;
  logic            underflow_reg;

  // Words currently on the stack; RET needs two, RTI needs three
  assign depth_w       = STACK_TOP - bus.sp_in;
  assign short_w       = depth_w < (bus.rti_req ? SP_W'(3) : SP_W'(2));
  assign bus.underflow = underflow_reg;
`else
  assign short_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      rti_mode_reg   <= 1'b0;
      pc_lo_reg      <= '0;
      pc_hi_reg      <= '0;
      mem_pop_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      pc_out_reg     <= '0;
      pc_load_reg    <= 1'b0;
      flags_out_reg  <= '0;
      flags_load_reg <= 1'b0;
      sp_out_reg     <= '0;
      sp_we_reg      <= 1'b0;
      stall_reg      <= 1'b0;
`ifdef STACK_UNDERFLOW_CHK_EN
      underflow_reg  <= 1'b0;
`endif
    end else begin
      mem_pop_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      pc_load_reg    <= 1'b0;
      flags_load_reg <= 1'b0;
      sp_we_reg      <= 1'b0;
`ifdef STACK_UNDERFLOW_CHK_EN
      underflow_reg  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (start_w) begin
            base_reg     <= bus.sp_in;
            rti_mode_reg <= bus.rti_req;
            stall_reg    <= 1'b1;
            if (short_w) begin
              state_reg <= DONE;
`ifdef STACK_UNDERFLOW_CHK_EN
              underflow_reg <= 1'b1;
`endif
            end else begin
              state_reg    <= POP_LO;
              mem_pop_reg  <= 1'b1;
              mem_addr_reg <= bus.sp_in + SP_W'(1);
            end
          end
        end
        POP_LO: begin
          state_reg    <= POP_HI;
          mem_pop_reg  <= 1'b1;
          mem_addr_reg <= base_reg + SP_W'(2);
        end
        POP_HI: begin
          pc_lo_reg <= bus.mem_rdata;
          if (rti_mode_reg) begin
            state_reg    <= POP_FL;
            mem_pop_reg  <= 1'b1;
            mem_addr_reg <= base_reg + SP_W'(3);
          end else begin
            state_reg <= DRAIN;
          end
        end
        POP_FL: begin
          pc_hi_reg <= bus.mem_rdata;
          state_reg <= DRAIN;
        end
        DRAIN: begin
          // The last popped word lands here; strobes are registered into DONE
          state_reg   <= DONE;
          pc_load_reg <= 1'b1;
          sp_we_reg   <= 1'b1;
          if (rti_mode_reg) begin
            pc_out_reg     <= {pc_hi_reg, pc_lo_reg};
            flags_out_reg  <= bus.mem_rdata[2:0];
            flags_load_reg <= 1'b1;
            sp_out_reg     <= base_reg + SP_W'(3);
          end else begin
            pc_out_reg <= {bus.mem_rdata, pc_lo_reg};
            sp_out_reg <= base_reg + SP_W'(2);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_pop    = mem_pop_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.pc_out     = pc_out_reg;
  assign bus.pc_load    = pc_load_reg;
  assign bus.flags_out  = flags_out_reg;
  assign bus.flags_load = flags_load_reg;
  assign bus.sp_out     = sp_out_reg;
  assign bus.sp_we      = sp_we_reg;
  assign bus.stall      = stall_reg;
endmodule

// File: tb/tb_stack_pop_unit.sv
// Directed bench for stack_pop_unit: table of RET/RTI vectors plus hand sequences
// for ignored requests, back-to-back requests, mid-sequence reset and stack wrap/underflow.
module tb_stack_pop_unit;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  stack_pop_unit_if bus_if ();

  stack_pop_unit #(.STACK_TOP(16'hFFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with a one-cycle registered read; unpopped cycles return 0
  logic [15:0] mem [int];
  always @(posedge clk) begin
    if (bus_if.mem_pop && mem.exists(int'(bus_if.mem_addr)))
      bus_if.mem_rdata <= mem[int'(bus_if.mem_addr)];
    else
      bus_if.mem_rdata <= 16'h0000;
  end

  typedef struct {
    logic        ret;
    logic        rti;
    logic [15:0] sp;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] w3;
    logic [31:0] pc;
    logic [2:0]  fl;
    logic [15:0] spo;
    int          lat;
    int          pops;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic load_mem(input logic [15:0] sp, input logic [15:0] w1, w2, w3);
    logic [15:0] a;
    a = sp + 16'd1; mem[int'(a)] = w1;
    a = sp + 16'd2; mem[int'(a)] = w2;
    a = sp + 16'd3; mem[int'(a)] = w3;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [15:0] a;
    int pops, loads, sws, fls, lat;
    logic stall_ok;
    mem.delete();
    load_mem(v.sp, v.w1, v.w2, v.w3);
    bus_if.ret_req = v.ret;
    bus_if.rti_req = v.rti;
    bus_if.sp_in   = v.sp;
    tick();
    bus_if.ret_req = 1'b0;
    bus_if.rti_req = 1'b0;
    pops = 0; loads = 0; sws = 0; fls = 0; lat = -1; stall_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (bus_if.mem_pop) begin
        a = v.sp + 16'(pops + 1);
        chk($sformatf("v%0d pop%0d addr", idx, pops), 32'(bus_if.mem_addr), 32'(a));
        pops++;
      end
      if (bus_if.pc_load) begin
        loads++;
        if (lat < 0) lat = c;
      end
      if (bus_if.sp_we) sws++;
      if (bus_if.flags_load) fls++;
      if ((c <= v.lat) != bus_if.stall) stall_ok = 1'b0;
      tick();
    end
    chk($sformatf("v%0d pops", idx), 32'(pops), 32'(v.pops));
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d pc_load count", idx), 32'(loads), 32'd1);
    chk($sformatf("v%0d sp_we count", idx), 32'(sws), 32'd1);
    chk($sformatf("v%0d flags_load count", idx), 32'(fls), v.rti ? 32'd1 : 32'd0);
    chk($sformatf("v%0d stall window", idx), 32'(stall_ok), 32'd1);
    chk($sformatf("v%0d pc_out", idx), bus_if.pc_out, v.pc);
    chk($sformatf("v%0d flags_out", idx), 32'(bus_if.flags_out), 32'(v.fl));
    chk($sformatf("v%0d sp_out", idx), 32'(bus_if.sp_out), 32'(v.spo));
  endtask

`ifdef STACK_UNDERFLOW_CHK_EN
  task automatic run_underflow(input logic ret, rti, input logic [15:0] sp, input string tag);
    int pops, strobes, uf_cnt, uf_cyc;
    logic stall1;
    pops = 0; strobes = 0; uf_cnt = 0; uf_cyc = -1; stall1 = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      bus_if.ret_req = (c == 0) ? ret : 1'b0;
      bus_if.rti_req = (c == 0) ? rti : 1'b0;
      bus_if.sp_in   = sp;
      if (bus_if.mem_pop) pops++;
      if (bus_if.pc_load || bus_if.sp_we || bus_if.flags_load) strobes++;
      if (bus_if.underflow) begin
        uf_cnt++;
        if (uf_cyc < 0) uf_cyc = c;
      end
      if (c == 1) stall1 = bus_if.stall;
      tick();
    end
    bus_if.ret_req = 1'b0;
    bus_if.rti_req = 1'b0;
    chk({tag, " pops"}, 32'(pops), 32'd0);
    chk({tag, " strobes"}, 32'(strobes), 32'd0);
    chk({tag, " underflow count"}, 32'(uf_cnt), 32'd1);
    chk({tag, " underflow cycle"}, 32'(uf_cyc), 32'd1);
    chk({tag, " stall at T+1"}, 32'(stall1), 32'd1);
  endtask
`endif

  initial begin
    int pops, loads, l1, l2, bad;
    logic stall_ok;
    logic [31:0] pc1, pc2;
    logic [15:0] sp1, sp2;
    checks = 0;
    failures = 0;

    vecs[0] = '{1'b1, 1'b0, 16'h0FF0, 16'h1234, 16'hABCD, 16'h0000, 32'hABCD1234, 3'b000, 16'h0FF2, 4, 2};
    vecs[1] = '{1'b0, 1'b1, 16'h0FF0, 16'h1234, 16'hABCD, 16'h0005, 32'hABCD1234, 3'b101, 16'h0FF3, 5, 3};
    vecs[2] = '{1'b1, 1'b1, 16'h2000, 16'h5555, 16'hAAAA, 16'h0FFA, 32'hAAAA5555, 3'b010, 16'h2003, 5, 3};
    vecs[3] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h8000, 16'h0007, 32'h80000001, 3'b010, 16'h8002, 4, 2};
`ifdef STACK_UNDERFLOW_CHK_EN
    vecs[4] = '{1'b1, 1'b0, 16'hFFFD, 16'h1357, 16'h2468, 16'h0000, 32'h24681357, 3'b010, 16'hFFFF, 4, 2};
`else
    vecs[4] = '{1'b1, 1'b0, 16'hFFFE, 16'hBEEF, 16'hCAFE, 16'h0000, 32'hCAFEBEEF, 3'b010, 16'h0000, 4, 2};
`endif

    reset = 1'b1;
    bus_if.ret_req = 1'b0;
    bus_if.rti_req = 1'b0;
    bus_if.sp_in   = 16'h0000;
    tick();
    tick();
    chk("reset pc_out", bus_if.pc_out, 32'h0);
    chk("reset flags_out", 32'(bus_if.flags_out), 32'h0);
    chk("reset sp_out", 32'(bus_if.sp_out), 32'h0);
    chk("reset mem_addr", 32'(bus_if.mem_addr), 32'h0);
    chk("reset strobes", {28'h0, bus_if.mem_pop, bus_if.pc_load, bus_if.flags_load, bus_if.sp_we}, 32'h0);
    chk("reset stall", 32'(bus_if.stall), 32'h0);
`ifdef STACK_UNDERFLOW_CHK_EN
    chk("reset underflow", 32'(bus_if.underflow), 32'h0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Both requests together, then a stray RET at T+2 that must be dropped
    mem.delete();
    load_mem(16'h0300, 16'hAAAA, 16'hBBBB, 16'h0006);
    pops = 0; loads = 0; l1 = -1; stall_ok = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      bus_if.ret_req = (c == 0) || (c == 2);
      bus_if.rti_req = (c == 0);
      bus_if.sp_in   = 16'h0300;
      if (bus_if.mem_pop) pops++;
      if (bus_if.pc_load) begin
        loads++;
        if (l1 < 0) l1 = c;
      end
      if (((c >= 1) && (c <= 5)) != bus_if.stall) stall_ok = 1'b0;
      tick();
    end
    bus_if.ret_req = 1'b0;
    bus_if.rti_req = 1'b0;
    chk("ign pops", 32'(pops), 32'd3);
    chk("ign pc_load count", 32'(loads), 32'd1);
    chk("ign latency", 32'(l1), 32'd5);
    chk("ign stall window", 32'(stall_ok), 32'd1);
    chk("ign pc_out", bus_if.pc_out, 32'hBBBBAAAA);
    chk("ign flags_out", 32'(bus_if.flags_out), 32'h6);
    chk("ign sp_out", 32'(bus_if.sp_out), 32'h0303);

    // Back-to-back RET at T and T+5
    mem.delete();
    load_mem(16'h0100, 16'h1111, 16'h2222, 16'h0000);
    load_mem(16'h0200, 16'h3333, 16'h4444, 16'h0000);
    pops = 0; loads = 0; l1 = -1; l2 = -1; pc1 = '0; pc2 = '0; sp1 = '0; sp2 = '0;
    for (int c = 0; c <= 12; c++) begin
      bus_if.ret_req = (c == 0) || (c == 5);
      bus_if.sp_in   = (c < 5) ? 16'h0100 : 16'h0200;
      if (bus_if.mem_pop) pops++;
      if (bus_if.pc_load) begin
        loads++;
        if (l1 < 0) begin
          l1 = c; pc1 = bus_if.pc_out; sp1 = bus_if.sp_out;
        end else begin
          l2 = c; pc2 = bus_if.pc_out; sp2 = bus_if.sp_out;
        end
      end
      tick();
    end
    bus_if.ret_req = 1'b0;
    chk("b2b pops", 32'(pops), 32'd4);
    chk("b2b pc_load count", 32'(loads), 32'd2);
    chk("b2b first cycle", 32'(l1), 32'd4);
    chk("b2b second cycle", 32'(l2), 32'd9);
    chk("b2b first pc", pc1, 32'h22221111);
    chk("b2b first sp", 32'(sp1), 32'h0102);
    chk("b2b second pc", pc2, 32'h44443333);
    chk("b2b second sp", 32'(sp2), 32'h0202);

`ifdef STACK_UNDERFLOW_CHK_EN
    run_underflow(1'b1, 1'b0, 16'hFFFE, "uf ret");
    run_underflow(1'b0, 1'b1, 16'hFFFD, "uf rti");
`endif

    // Reset while in POP_HI
    mem.delete();
    load_mem(16'h0400, 16'h5A5A, 16'hA5A5, 16'h0000);
    bus_if.ret_req = 1'b1;
    bus_if.sp_in   = 16'h0400;
    tick();
    bus_if.ret_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst-mid stall", 32'(bus_if.stall), 32'h0);
    chk("rst-mid pc_out", bus_if.pc_out, 32'h0);
    chk("rst-mid flags_out", 32'(bus_if.flags_out), 32'h0);
    chk("rst-mid sp_out", 32'(bus_if.sp_out), 32'h0);
    chk("rst-mid mem_addr", 32'(bus_if.mem_addr), 32'h0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus_if.pc_load || bus_if.sp_we || bus_if.mem_pop || bus_if.stall) bad++;
      tick();
    end
    chk("rst-mid quiet after reset", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
